// File: rtl/rng_pkg.sv
// Shared types and constants for the LFSR random source: FSM states,
// known maximal-length Galois tap masks and the draw-attempt counter width.
package rng_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    // Right-shifting Galois masks giving period 2^W-1
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

    // One spare bit so the counter can hold MAX_TRIES itself
    function automatic int tries_w(input int max_tries);
        return $clog2(max_tries) + 1;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Galois LFSR with a seed-load port. Steps every edge; a zero
// seed is forced to 1 so the lock-up state can never be entered.
module lfsr_core
    import rng_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = TAPS_16,
    parameter logic [LFSR_W-1:0] SEED   = 16'h0001
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] step;

    assign step = (state >> 1) ^ (state[0] ? TAPS : '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= SEED;
        else if (load)
            state <= (load_val == '0) ? LFSR_W'(1) : load_val;
        else
            state <= step;
    end

endmodule

// File: rtl/lfsr_random_gen.sv
// Request/valid random number source: draws LFSR candidates, rejects those
// out of range (or repeating the last draw), and falls back after MAX_TRIES.
module lfsr_random_gen
    import rng_pkg::*;
#(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED      = 16'h0001,
    parameter int                OUT_W     = 10,
    parameter int                RANGE     = 1000,
    parameter int                NO_REPEAT = 1,
    parameter int                MAX_TRIES = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_val,
    input  logic              req,
    output logic              busy,
    output logic              valid,
    output logic [OUT_W-1:0]  randnum
);

    localparam int TW = tries_w(MAX_TRIES);
    // One extra bit so RANGE == 2^OUT_W is representable
    localparam logic [OUT_W:0]  RANGE_C  = (OUT_W+1)'(RANGE);
    localparam logic [OUT_W:0]  LAST_VAL = RANGE_C - 1'b1;
    localparam logic [TW-1:0]   LAST_TRY = TW'(MAX_TRIES - 1);

    logic [LFSR_W-1:0] lfsr;
    logic [OUT_W-1:0]  cand;
    logic [OUT_W-1:0]  fallback;
    logic              accept;

    state_t            state_q, state_d;
    logic [TW-1:0]     tries_q, tries_d;
    logic              busy_d, valid_d, have_last_q, have_last_d;
    logic [OUT_W-1:0]  randnum_d;

    lfsr_core #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_core (
        .clk      (clk),
        .resetn   (resetn),
        .load     (seed_load),
        .load_val (seed_val),
        .state    (lfsr)
    );

    assign cand = lfsr[OUT_W-1:0];

    generate
        if (OUT_W < LFSR_W) begin : g_unused_hi
            logic unused_lfsr_hi;
            assign unused_lfsr_hi = ^lfsr[LFSR_W-1:OUT_W];
        end
    endgenerate

    assign accept = ({1'b0, cand} < RANGE_C) &&
                    !((NO_REPEAT != 0) && have_last_q && (cand == randnum));

    // Stepping past the last draw stays in range and differs from it
    assign fallback = ({1'b0, randnum} == LAST_VAL) ? '0 : randnum + OUT_W'(1);

    always_comb begin
        state_d     = state_q;
        tries_d     = tries_q;
        busy_d      = busy;
        valid_d     = 1'b0;
        randnum_d   = randnum;
        have_last_d = have_last_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = DRAW;
                    busy_d  = 1'b1;
                    tries_d = '0;
                end
            end
            DRAW: begin
                tries_d = tries_q + TW'(1);
                if (accept || (tries_q == LAST_TRY)) begin
                    randnum_d   = accept ? cand : fallback;
                    valid_d     = 1'b1;
                    have_last_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            tries_q     <= '0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            randnum     <= '0;
            have_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tries_q     <= tries_d;
            busy        <= busy_d;
            valid       <= valid_d;
            randnum     <= randnum_d;
            have_last_q <= have_last_d;
        end
    end

endmodule

// File: tb/tb_lfsr_random_gen.sv
// Scoreboard bench: two instances (defaults, and MAX_TRIES=1/NO_REPEAT=0)
// share stimulus; a draw-level model predicts each accepted number.
module tb_lfsr_random_gen;

    localparam int RANGE = 1000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_val = '0;
    logic        req = 1'b0;
    logic [1:0]  busy, valid;
    logic [9:0]  randnum [2];

    lfsr_random_gen u0 (
        .clk(clk), .resetn(resetn), .seed_load(seed_load), .seed_val(seed_val),
        .req(req), .busy(busy[0]), .valid(valid[0]), .randnum(randnum[0])
    );

    lfsr_random_gen #(.MAX_TRIES(1), .NO_REPEAT(0)) u1 (
        .clk(clk), .resetn(resetn), .seed_load(seed_load), .seed_val(seed_val),
        .req(req), .busy(busy[1]), .valid(valid[1]), .randnum(randnum[1])
    );

    always #5 clk = ~clk;

    typedef struct {int val; int cyc;} exp_t;
    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state
    int m_lfsr = 1;
    int m_busy[2], m_tries[2], m_rand[2], m_have[2];
    int mt[2] = '{8, 1};
    int nr[2] = '{1, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lstep(input int v);
        return (v >> 1) ^ (((v & 1) != 0) ? 'hB400 : 0);
    endfunction

    task automatic push(input int i);
        exp_t e;
        e.val = m_rand[i];
        e.cyc = cyc;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
        m_have[i] = 1;
        m_busy[i] = 0;
    endtask

    // One clock edge of the draw rules, applied to every instance
    task automatic model_edge(input bit sl, input int sv, input bit rq);
        int cand;
        cand = m_lfsr % 1024;
        for (int i = 0; i < 2; i++) begin
            if (m_busy[i] == 0) begin
                if (rq) begin m_busy[i] = 1; m_tries[i] = 0; end
            end else if (cand < RANGE && !(nr[i] != 0 && m_have[i] != 0 && cand == m_rand[i])) begin
                m_rand[i] = cand;
                push(i);
            end else if (m_tries[i] == mt[i] - 1) begin
                m_rand[i] = (m_rand[i] + 1) % RANGE;
                push(i);
            end else begin
                m_tries[i]++;
            end
        end
        m_lfsr = sl ? ((sv == 0) ? 1 : sv) : lstep(m_lfsr);
    endtask

    task automatic model_reset();
        m_lfsr = 1;
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_tries[i] = 0; m_rand[i] = 0; m_have[i] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic cyc_go(input bit sl, input logic [15:0] sv, input bit rq);
        seed_load = sl;
        seed_val  = sv;
        req       = rq;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(sl, int'(sv), rq);
        chk("busy_u0", busy[0], m_busy[0]);
        chk("busy_u1", busy[1], m_busy[1]);
        chk("lfsr", u0.lfsr, m_lfsr);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", busy[i], 0);
            chk("rst_valid", valid[i], 0);
            chk("rst_randnum", randnum[i], 0);
        end
        #1;
        resetn = 1'b1;
    endtask

    // Seed and request together; u0 must pulse after n0 edges, u1 after n1
    task automatic seeded_req(input logic [15:0] sv, input int n0, input int e0,
                              input int n1, input int e1);
        cyc_go(1'b1, sv, 1'b1);
        chk("busy_after_req", busy[0], 1);
        for (int t = 2; t <= 5; t++) begin
            cyc_go(1'b0, 16'h0, 1'b0);
            if (t == n0) begin
                chk("dir_valid_u0", valid[0], 1);
                chk("dir_randnum_u0", randnum[0], e0);
            end
            if (t == n1) begin
                chk("dir_valid_u1", valid[1], 1);
                chk("dir_randnum_u1", randnum[1], e1);
            end
        end
    endtask

    task automatic mon(input int i);
        exp_t e;
        int sz;
        sz = (i == 0) ? q0.size() : q1.size();
        if (valid[i]) begin
            checks++;
            if (sz == 0) begin
                errors++;
                $display("FAIL extra_valid_u%0d randnum=%0d expected no pulse (cycle %0d)", i, randnum[i], cyc);
            end else begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("sb_randnum_u%0d", i), randnum[i], e.val);
                chk($sformatf("sb_cycle_u%0d", i), cyc, e.cyc);
            end
        end else if (sz != 0) begin
            e = (i == 0) ? q0[0] : q1[0];
            if (e.cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_valid_u%0d valid=0 expected pulse with %0d", i, e.val);
                if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        #1_500_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int r;
        logic [15:0] sv;
        logic [15:0] seq [5];
        seq[0] = 16'h0001; seq[1] = 16'hB400; seq[2] = 16'h5A00;
        seq[3] = 16'h2D00; seq[4] = 16'h1680;
        model_reset();
        #12;
        resetn = 1'b1;

        // Free run from SEED, no requests
        chk("reset_lfsr", u0.lfsr, seq[0]);
        chk("reset_busy", busy, 0);
        chk("reset_valid", valid, 0);
        chk("reset_randnum", randnum[0], 0);
        for (int k = 1; k < 5; k++) begin
            cyc_go(1'b0, 16'h0, 1'b0);
            chk("freerun_lfsr", u0.lfsr, seq[k]);
            chk("freerun_valid", valid, 0);
            chk("freerun_randnum", randnum[0] | randnum[1], 0);
        end

        // Zero seed maps to 1, then full period
        cyc_go(1'b1, 16'h0000, 1'b0);
        chk("seed0_lfsr", u0.lfsr, 1);
        n = 0;
        do begin
            cyc_go(1'b0, 16'h0, 1'b0);
            n++;
        end while (u0.lfsr != 16'h0001 && n < 70000);
        chk("period", n, 65535);

        seeded_req(16'h0005, 2, 5, 2, 5);
        seeded_req(16'h0005, 3, 2, 2, 5);      // no-repeat rejects 5 in u0
        seeded_req(16'h03E7, 2, 999, 2, 999);
        seeded_req(16'h03FF, 3, 511, 2, 0);    // u1 falls back 999 -> 0

        // Request while busy is ignored
        cyc_go(1'b1, 16'h03FF, 1'b1);
        cyc_go(1'b0, 16'h0, 1'b1);
        for (int k = 0; k < 4; k++) cyc_go(1'b0, 16'h0, 1'b0);

        // Reset in the middle of a draw: no pulse afterwards
        cyc_go(1'b1, 16'h03FF, 1'b1);
        do_reset();
        for (int k = 0; k < 4; k++) cyc_go(1'b0, 16'h0, 1'b0);

        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(3);
            case (r)
                0: sv = 16'h0000;
                1: sv = 16'($urandom_range(1023));
                2: sv = 16'h03FF;
                default: sv = 16'($urandom);
            endcase
            cyc_go($urandom_range(9) == 0, sv, $urandom_range(2) == 0);
            if ($urandom_range(399) == 0) do_reset();
        end

        for (int k = 0; k < 12; k++) cyc_go(1'b0, 16'h0, 1'b0);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_random_gen.md
Name: lfsr_random_gen

Overview:
Parametrised pseudo-random number source for the memory-game datapath. It replaces the sampled free-running counter with a maximal-length Galois LFSR, and adds seeding, a request/valid handshake, unbiased range reduction by rejection, and an optional no-immediate-repeat mode. It sits between the game FSM, which requests the next tile or position, and the sequence store.

Parameters:
LFSR_W, 16, LFSR width in bits
TAPS, 16'hB400, Galois feedback mask; must be maximal-length for LFSR_W
SEED, 16'h0001, reset value of the LFSR; must be nonzero
OUT_W, 10, width of randnum
RANGE, 1000, accepted outputs are 0..RANGE-1; 1 < RANGE <= 2^OUT_W
NO_REPEAT, 1, when 1, a draw never equals the previous accepted draw
MAX_TRIES, 8, candidates evaluated per request before the fallback is used

Ports:
clk, in, 1, clock
resetn, in, 1, reset: asynchronous, active-low
seed_load, in, 1, load seed_val into the LFSR this edge
seed_val, in, LFSR_W, seed value; zero is replaced by 1
req, in, 1, request a new number; sampled only when busy=0
busy, out, 1, draw in progress
valid, out, 1, one-cycle pulse: randnum updated
randnum, out, OUT_W, last accepted number; held between draws

Behaviour:
- Reset (async): lfsr=SEED, randnum=0, valid=0, busy=0, state=IDLE, tries=0, have_last=0.
- LFSR advances one step on every clk edge, independent of requests. This keeps entropy from user timing.
- LFSR step: lsb=lfsr[0]; next=(lfsr>>1) xor (lsb ? TAPS : 0).
- seed_load has priority over the step: lfsr := (seed_val==0) ? 1 : seed_val. The all-zero lock-up state is unreachable.
- Candidate cand = lfsr[OUT_W-1:0], taken from the current register value.
- FSM states: IDLE, DRAW.
- IDLE: when req=1, go to DRAW, set busy=1 and tries=0. With req=0, stay in IDLE.
- DRAW: each cycle, evaluate cand and then tries++.
  - Accept when cand < RANGE and !(NO_REPEAT and have_last and cand==randnum).
  - On accept: randnum:=cand, valid=1 for one cycle, have_last:=1, busy:=0, go to IDLE.
  - On reject with tries==MAX_TRIES-1: randnum := (randnum==RANGE-1) ? 0 : randnum+1. Then pulse valid, set have_last, clear busy, go to IDLE.
  - Otherwise stay in DRAW. The LFSR has stepped, giving a new candidate next cycle.
- Latency: req seen at edge k; first candidate evaluated at edge k+1. Best case, valid is high in the cycle after edge k+1. Worst case is MAX_TRIES+1 edges after req.
- req while busy=1 is ignored and not queued.
- req held high: a new draw starts on the edge after valid, because busy=0 is seen in IDLE.
- seed_load with req in the same cycle: the seed is loaded and req is accepted. The first DRAW candidate is seed_val[OUT_W-1:0].
- seed_load during DRAW: the LFSR reloads and the draw continues. tries is not reset.
- Reset mid-DRAW: everything returns to reset values, and no valid pulse is produced.
- The fallback result stays below RANGE. When have_last=1, it also differs from the previous draw.
- Arithmetic: the cand < RANGE compare uses OUT_W+1 bits so that RANGE=2^OUT_W is legal. tries has width clog2(MAX_TRIES)+1.

Decomposition:
- Shared package rng_pkg holds:
  - the state enum {IDLE, DRAW};
  - a localparam table of maximal taps for widths 8, 16 and 32;
  - a constant function for the tries counter width.
- One sub-module, lfsr_core, contains the LFSR register, step logic and seed-load mux. Its ports are clk, resetn, load, load_val, state.
- The FSM, acceptance and fallback logic stay in lfsr_random_gen.

Test Plan:
- Reset, then run free with defaults → lfsr goes 0x0001→0xB400→0x5A00→0x2D00→0x1680. randnum=0, valid=0, busy=0 throughout.
- seed_load=1 with seed_val=0 → lfsr=0x0001 on the next edge. Period check: from seed 1, state 0x0001 recurs after exactly 65535 steps.
- seed_load with seed_val=0x0005 and req in the same cycle (RANGE=1000, NO_REPEAT=0) → valid pulses 2 edges after req, with randnum=5. busy is high for exactly 1 cycle.
- seed_val=0x03FF with req (cand=1023, rejected) → busy stays high one extra cycle. The next candidate is (0x03FF>>1)^0xB400 = 0xB5FF, giving low 10 bits 0x1FF=511. valid pulses with randnum=511.
- MAX_TRIES=1, RANGE=1000, prior randnum=999, seed_val=0x03FF with req → fallback gives randnum=0 and valid pulses 2 edges after req.
- NO_REPEAT=1: accept 5, then reload seed 0x0005 with req → candidate 5 is rejected and a different value below RANGE is output. Also: a second req during busy produces no additional valid. Also: resetn pulsed mid-DRAW gives busy=0, randnum=0 and no valid.
